// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame length, common command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        WAIT_ACK,
        WAIT_IDLE,
        DONE,
        ERROR
    } state_t;

    localparam int FRAME_FALLS = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises an asynchronous PS/2 line, debounces it over FILTER_CYCLES samples,
// and flags a 1->0 transition of the filtered level. Latency: 2 sync + FILTER_CYCLES cycles.
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] run;
    logic          level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync    <= 2'b11;
            run     <= '0;
            level   <= 1'b1;
            level_q <= 1'b1;
        end else begin
            sync    <= {sync[0], raw};
            level_q <= level;
            // run counts consecutive samples that disagree with the current level
            if (sync[1] == level) begin
                run <= '0;
            end else if (run == CW'(FILTER_CYCLES - 1)) begin
                level <= sync[1];
                run   <= '0;
            end else begin
                run <= run + CW'(1);
            end
        end
    end

    assign fall = level_q & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, sends start/8 data/parity/stop on device
// clock falls, checks the ACK, and reports done or error. Lines are only ever pulled low via *_oe.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES     = 6000,
    parameter int SETUP_CYCLES       = 50,
    parameter int FIRST_EDGE_TIMEOUT = 750000,
    parameter int BIT_TIMEOUT        = 100000,
    parameter int FILTER_CYCLES      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam int CNT_MAX = max_int(max_int(INHIBIT_CYCLES, SETUP_CYCLES),
                                     max_int(FIRST_EDGE_TIMEOUT, BIT_TIMEOUT));
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int IW = $clog2(FRAME_FALLS + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] bit_idx;
    logic [7:0]    data;
    logic          parity;
    logic [1:0]    dat_sync;
    logic          clk_level;
    logic          clk_fall;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .clock (clock),
        .reset (reset),
        .raw   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    always_ff @(posedge clock) begin
        if (reset) dat_sync <= 2'b11;
        else       dat_sync <= {dat_sync[0], ps2_dat_in};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            data       <= '0;
            parity     <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        data       <= tx_data;
                        parity     <= ~^tx_data;
                        cnt        <= CW'(INHIBIT_CYCLES - 1);
                        ps2_clk_oe <= 1'b1;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == '0) begin
                        ps2_dat_oe <= 1'b1;
                        cnt        <= CW'(SETUP_CYCLES - 1);
                        state      <= START;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        ps2_clk_oe <= 1'b0;
                        bit_idx    <= '0;
                        cnt        <= CW'(FIRST_EDGE_TIMEOUT);
                        state      <= SEND;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SEND: begin
                    // a fall in the same cycle as expiry still counts
                    if (clk_fall) begin
                        bit_idx <= bit_idx + IW'(1);
                        cnt     <= CW'(BIT_TIMEOUT);
                        if (bit_idx < IW'(8)) begin
                            ps2_dat_oe <= ~data[bit_idx[2:0]];
                        end else if (bit_idx == IW'(8)) begin
                            ps2_dat_oe <= ~parity;
                        end else begin
                            ps2_dat_oe <= 1'b0;
                            state      <= WAIT_ACK;
                        end
                    end else if (cnt == '0) begin
                        tx_error   <= 1'b1;
                        ps2_dat_oe <= 1'b0;
                        state      <= ERROR;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WAIT_ACK: begin
                    if (clk_fall) begin
                        bit_idx <= bit_idx + IW'(1);
                        cnt     <= CW'(BIT_TIMEOUT);
                        if (!dat_sync[1]) begin
                            state <= WAIT_IDLE;
                        end else begin
                            tx_error <= 1'b1;
                            state    <= ERROR;
                        end
                    end else if (cnt == '0) begin
                        tx_error <= 1'b1;
                        state    <= ERROR;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (clk_level && dat_sync[1]) begin
                        tx_done <= 1'b1;
                        state   <= DONE;
                    end else if (cnt == '0) begin
                        tx_error <= 1'b1;
                        state    <= ERROR;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE, ERROR: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    tx_ready   <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard drives the open-drain lines and records the frame.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH   = 60;
    localparam int SETUP = 10;
    localparam int FIRST = 400;
    localparam int BITTO = 200;
    localparam int FILT  = 8;
    localparam int H     = 25;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] tx_data  = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk  = 1'b1;
    logic       dev_dat  = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    int checks   = 0;
    int fails    = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES     (INH),
        .SETUP_CYCLES       (SETUP),
        .FIRST_EDGE_TIMEOUT (FIRST),
        .BIT_TIMEOUT        (BITTO),
        .FILTER_CYCLES      (FILT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (tx_done)             done_cnt++;
        if (tx_error)            err_cnt++;
        if (tx_done && tx_error) both_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    // Frame as the keyboard should see it: {stop, odd parity, data LSB first}
    function automatic logic [9:0] expected_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit ack, input int glitch_after,
                        input int reset_after, input bit hold_valid,
                        output int inh_len, output logic [9:0] bits,
                        output int done_d, output int err_d,
                        output logic [5:0] snap, output bit stalled);
        int d0, e0, n;
        d0 = done_cnt; e0 = err_cnt;
        inh_len = 0; bits = '0; snap = '0; stalled = 1'b0; n = 0;
        tx_data = d; tx_valid = 1'b1;
        tick(1);
        if (hold_valid) tx_data = ~d;
        else            tx_valid = 1'b0;
        while (ps2_clk_oe && !ps2_dat_oe && inh_len < 4 * INH) begin
            inh_len++; tick(1);
        end
        while (ps2_clk_oe && n < 4 * (INH + SETUP)) begin
            n++; tick(1);
        end
        if (ps2_clk_oe || !ps2_dat_oe) stalled = 1'b1;
        if (!stalled) begin
            tick(H);
            for (int k = 1; k <= FRAME_FALLS; k++) begin
                if (k == FRAME_FALLS) begin
                    dev_dat = !ack;
                    tick(4);
                end
                dev_clk = 1'b0;
                tick(H);
                if (k < FRAME_FALLS) bits[k-1] = ps2_dat_in;
                if (k == reset_after) begin
                    reset = 1'b1;
                    tick(1);
                    snap = {tx_ready, busy, ps2_clk_oe, ps2_dat_oe, tx_done, tx_error};
                    reset = 1'b0; dev_clk = 1'b1; dev_dat = 1'b1;
                    break;
                end
                dev_clk = 1'b1;
                if (k == glitch_after) begin
                    tick(8); dev_clk = 1'b0; tick(3); dev_clk = 1'b1; tick(H - 11);
                end else if (k < FRAME_FALLS) begin
                    tick(H);
                end
            end
            dev_clk = 1'b1; dev_dat = 1'b1;
        end
        n = 0;
        while (reset_after == 0 && done_cnt == d0 && err_cnt == e0 &&
               !tx_done && !tx_error && n < 4 * BITTO) begin
            n++; tick(1);
        end
        if (reset_after == 0 && done_cnt == d0 && err_cnt == e0 && !tx_done && !tx_error)
            stalled = 1'b1;
        tx_valid = 1'b0;
        tick(20);
        done_d = done_cnt - d0;
        err_d  = err_cnt - e0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        checks++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_dat_oe, tx_done, tx_error} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_state: got %b want 100000",
                     {tx_ready, busy, ps2_clk_oe, ps2_dat_oe, tx_done, tx_error});
        end
        reset = 1'b0;
        tick(5);
        checks++;
        if (busy !== 1'b0 || tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b ready=%b want 0/1", busy, tx_ready);
        end
    endtask

    task automatic test_set_leds();
        int inh, dd, ed; logic [9:0] bits; logic [5:0] snap; bit st;
        logic seq[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] want;
        for (int i = 0; i < 8; i++) want[i] = seq[i];
        send(CMD_SET_LEDS, 1'b1, 0, 0, 1'b0, inh, bits, dd, ed, snap, st);
        checks++;
        if (st) begin fails++; $display("FAIL set_leds_progress: transfer stalled"); end
        checks++;
        if (inh != INH) begin fails++; $display("FAIL set_leds_inhibit: got %0d want %0d", inh, INH); end
        checks++;
        if (bits[7:0] !== want) begin fails++; $display("FAIL set_leds_bits: got %b want %b", bits[7:0], want); end
        checks++;
        if (bits[9:8] !== 2'b11) begin fails++; $display("FAIL set_leds_par_stop: got %b want 11", bits[9:8]); end
        checks++;
        if (dd != 1 || ed != 0) begin fails++; $display("FAIL set_leds_pulses: done=%0d err=%0d want 1/0", dd, ed); end
        checks++;
        if (tx_ready !== 1'b1) begin fails++; $display("FAIL set_leds_ready: got %b want 1", tx_ready); end
    endtask

    task automatic test_parity();
        int inh, dd, ed; logic [9:0] bits; logic [5:0] snap; bit st;
        logic [7:0] cmds[3] = '{8'h00, 8'hFF, 8'h01};
        logic       pars[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            send(cmds[i], 1'b1, 0, 0, 1'b0, inh, bits, dd, ed, snap, st);
            checks++;
            if (bits[8] !== pars[i] || bits[7:0] !== cmds[i]) begin
                fails++;
                $display("FAIL parity_%02h: got data %02h par %b want %02h par %b",
                         cmds[i], bits[7:0], bits[8], cmds[i], pars[i]);
            end
            checks++;
            if (dd != 1 || ed != 0) begin
                fails++;
                $display("FAIL parity_%02h_done: done=%0d err=%0d want 1/0", cmds[i], dd, ed);
            end
        end
    endtask

    task automatic test_random();
        int inh, dd, ed; logic [9:0] bits; logic [5:0] snap; bit st;
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            send(d, 1'b1, 0, 0, 1'b0, inh, bits, dd, ed, snap, st);
            checks++;
            if (bits !== expected_frame(d) || dd != 1 || ed != 0) begin
                fails++;
                $display("FAIL random_%02h: frame %b done %0d err %0d want frame %b done 1 err 0",
                         d, bits, dd, ed, expected_frame(d));
            end
        end
    endtask

    task automatic test_timeout();
        int n, d0, e0, want;
        want = INH + SETUP + FIRST;
        d0 = done_cnt; e0 = err_cnt; n = 0;
        tx_data = CMD_RESET; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        while (!tx_error && n < 2 * want) begin n++; tick(1); end
        checks++;
        if (n < want - 2 || n > want + 2) begin
            fails++;
            $display("FAIL timeout_latency: got %0d cycles want %0d", n, want);
        end
        tick(2);
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            fails++;
            $display("FAIL timeout_release: clk_oe=%b dat_oe=%b want 0/0", ps2_clk_oe, ps2_dat_oe);
        end
        checks++;
        if (done_cnt != d0 || err_cnt != e0 + 1) begin
            fails++;
            $display("FAIL timeout_pulses: done=%0d err=%0d want 0/1", done_cnt - d0, err_cnt - e0);
        end
        tick(10);
    endtask

    task automatic test_nack();
        int inh, dd, ed; logic [9:0] bits; logic [5:0] snap; bit st;
        send(CMD_ECHO, 1'b0, 0, 0, 1'b0, inh, bits, dd, ed, snap, st);
        checks++;
        if (dd != 0 || ed != 1) begin fails++; $display("FAIL nack_pulses: done=%0d err=%0d want 0/1", dd, ed); end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL nack_idle: clk_oe=%b dat_oe=%b ready=%b want 0/0/1", ps2_clk_oe, ps2_dat_oe, tx_ready);
        end
    endtask

    task automatic test_reset_mid();
        int inh, dd, ed; logic [9:0] bits; logic [5:0] snap; bit st;
        send(8'hA5, 1'b1, 0, 4, 1'b0, inh, bits, dd, ed, snap, st);
        checks++;
        if (snap !== 6'b100000) begin fails++; $display("FAIL reset_mid_state: got %b want 100000", snap); end
        checks++;
        if (dd != 0 || ed != 0) begin fails++; $display("FAIL reset_mid_pulses: done=%0d err=%0d want 0/0", dd, ed); end
        send(CMD_ECHO, 1'b1, 0, 0, 1'b0, inh, bits, dd, ed, snap, st);
        checks++;
        if (bits !== expected_frame(CMD_ECHO) || dd != 1 || ed != 0) begin
            fails++;
            $display("FAIL reset_mid_resend: frame %b done %0d err %0d want %b 1 0",
                     bits, dd, ed, expected_frame(CMD_ECHO));
        end
    endtask

    task automatic test_glitch();
        int inh, dd, ed; logic [9:0] bits; logic [5:0] snap; bit st;
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        send(d, 1'b1, 3, 0, 1'b0, inh, bits, dd, ed, snap, st);
        checks++;
        if (bits !== expected_frame(d) || dd != 1 || ed != 0) begin
            fails++;
            $display("FAIL glitch_frame: frame %b done %0d err %0d want %b 1 0", bits, dd, ed, expected_frame(d));
        end
    endtask

    task automatic test_hold_valid();
        int inh, dd, ed, d0; logic [9:0] bits; logic [5:0] snap; bit st;
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        send(d, 1'b1, 0, 0, 1'b1, inh, bits, dd, ed, snap, st);
        checks++;
        if (bits !== expected_frame(d) || dd != 1 || ed != 0) begin
            fails++;
            $display("FAIL hold_valid_frame: frame %b done %0d err %0d want %b 1 0", bits, dd, ed, expected_frame(d));
        end
        d0 = done_cnt;
        tick(100);
        checks++;
        if (busy !== 1'b0 || ps2_clk_oe !== 1'b0 || done_cnt != d0) begin
            fails++;
            $display("FAIL hold_valid_single: busy=%b clk_oe=%b extra_done=%0d want 0/0/0", busy, ps2_clk_oe, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_set_leds();
        test_parity();
        test_random();
        test_timeout();
        test_nack();
        test_reset_mid();
        test_glitch();
        test_hold_valid();
        checks++;
        if (both_cnt != 0) begin fails++; $display("FAIL done_error_exclusive: overlap cycles %0d want 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
